inject_queue_stage: RTL and testbench
=====================================

// Module: inject_queue_stage
// PURPOSE
//  Registered injection stage for the bufferless deflection router: merges locally generated flits into
//  free slots of the NPORTS in-flight flit bundle before route computation. Replaces tri-state "z = empty"
//  slots with explicit valid bits, buffers local flits in a QDEPTH FIFO and flags injection starvation.
//  Sits between the router input latches and the permutation/route stage; port i order 0=E,1=W,2=N,3=S.
// PARAMETERS
//  FLIT_W      10  flit width in bits (address field included, passed through untouched)
//  NPORTS      4   number of directional slots in the bundle
//  QDEPTH      4   local injection FIFO depth; power of two, >=2
//  STARVE_MAX  15  consecutive blocked cycles before starve_flag asserts (>=1)
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               synchronous active-high reset
//  in_flit     in   NPORTS*FLIT_W   incoming flits; slot i = in_flit[i*FLIT_W +: FLIT_W]
//  in_valid    in   NPORTS          slot i holds a live flit
//  loc_flit    in   FLIT_W          flit from local PE
//  loc_valid   in   1               local PE offers loc_flit
//  loc_ready   out  1               FIFO can accept (count < QDEPTH)
//  out_flit    out  NPORTS*FLIT_W   registered bundle after injection
//  out_valid   out  NPORTS          registered slot valids
//  inj_fire    out  1               registered: a local flit was injected into out bundle this cycle
//  inj_slot    out  $clog2(NPORTS)  registered index of injected slot (valid when inj_fire)
//  starve_flag out  1               registered: starvation counter == STARVE_MAX
//  q_count     out  $clog2(QDEPTH+1) current FIFO occupancy
// BEHAVIOUR
//  - Reset: out_flit=0, out_valid=0, inj_fire=0, inj_slot=0, starve_flag=0, FIFO empty (q_count=0,
//    rd/wr pointers 0), starve counter 0; loc_ready=1 the cycle after rst deasserts. rst mid-operation
//    discards all queued flits and clears the output register in the same edge.
//  - Push: loc_valid && loc_ready at edge -> loc_flit written at wr_ptr, wr_ptr wraps modulo QDEPTH.
//    loc_ready is purely count-based: when full it stays 0 even if a pop occurs that cycle (no pass-through).
//  - No FIFO bypass: flit accepted at edge t is eligible for injection in cycle t+1, appears on out at t+2.
//  - Injection decision (combinational on current inputs): free = ~in_valid. If q_count!=0 and free!=0,
//    head flit goes to lowest-index free slot; FIFO pops (rd_ptr wraps). Else no pop.
//  - Output register each edge: out_flit/out_valid = in bundle with injected slot overwritten and its valid
//    set; non-injected slots copied verbatim, invalid slots' data copied but ignored. Through latency 1 cycle.
//  - Simultaneous push and pop: q_count unchanged, both pointers advance; legal at any occupancy incl. 1.
//  - Starvation: blocked = (q_count!=0 && free==0). Counter increments on blocked, saturates at STARVE_MAX,
//    clears to 0 on any cycle not blocked. starve_flag = (counter==STARVE_MAX), registered; drops one edge
//    after the first successful injection. Flag is advisory (consumed by upstream deflection arbiter).
//  - Never drops a live incoming flit; out_valid popcount = in_valid popcount + inj (inj in {0,1}).
// TESTING
//  1 Reset: hold rst 2 cycles with loc_valid=1 -> out_valid=0, q_count=0, no push; release -> loc_ready=1.
//  2 Free slot: q holds 10'h03F, in_valid=4'b1011 -> next edge out slot2=10'h03F, out_valid=4'b1111,
//    inj_fire=1, inj_slot=2, q_count=0.
//  3 All busy: in_valid=4'b1111 for 20 cycles with q_count=1 -> no pop, starve_flag=1 from 16th edge on;
//    then in_valid=4'b0111 -> slot3 injected, flag 0 one edge later.
//  4 Fill/wrap: push 6 flits 10'h001..10'h006 with in_valid=4'b1111 -> loc_ready=0 after 4 accepted;
//    open slots -> injected in order 001,002,003,004; pointers wrap cleanly on later pushes.
//  5 Push+pop same cycle at q_count=1, in_valid=4'b0000 -> slot0 gets old head, q_count stays 1.
//  6 Pass-through: q empty, in bundle {S,N,W,E}={10'h005,z,10'h221,10'h027} valid 4'b1011 -> identical
//    bundle one cycle later, inj_fire=0.

Source files
------------

// File: rtl/inject_queue_stage.sv
// Injection stage for the deflection router: buffers local flits in a small FIFO and merges
// the head flit into the lowest free slot of the in-flight bundle, flagging sustained starvation.
module inject_queue_stage #(
   parameter int unsigned FLIT_W     = 10,
   parameter int unsigned NPORTS     = 4,
   parameter int unsigned QDEPTH     = 4,
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NPORTS*FLIT_W-1:0]     in_flit,
   input  logic [NPORTS-1:0]            in_valid,
   input  logic [FLIT_W-1:0]            loc_flit,
   input  logic                         loc_valid,
   output logic                         loc_ready,
   output logic [NPORTS*FLIT_W-1:0]     out_flit,
   output logic [NPORTS-1:0]            out_valid,
   output logic                         inj_fire,
   output logic [$clog2(NPORTS)-1:0]    inj_slot,
   output logic                         starve_flag,
   output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

   localparam int unsigned SLOT_W = $clog2(NPORTS);
   localparam int unsigned PTR_W  = $clog2(QDEPTH);
   localparam int unsigned CNT_W  = $clog2(QDEPTH+1);
   localparam int unsigned ST_W   = $clog2(STARVE_MAX+1);

   logic [FLIT_W-1:0]        mem [QDEPTH];
   logic [PTR_W-1:0]         rd_ptr, wr_ptr;
   logic [ST_W-1:0]          starve_cnt;

   logic                     any_free, inj, push, blocked;
   logic [SLOT_W-1:0]        slot;
   logic [CNT_W-1:0]         count_next;
   logic [NPORTS*FLIT_W-1:0] bundle_flit;
   logic [NPORTS-1:0]        bundle_valid;

   // Lowest free slot search, bundle merge and FIFO bookkeeping
   always_comb begin
      any_free     = 1'b0;
      slot         = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (!in_valid[i] && !any_free) begin
            any_free = 1'b1;
            slot     = SLOT_W'(i);
         end
      end
      inj          = any_free && (q_count != '0);
      blocked      = !any_free && (q_count != '0);
      push         = loc_valid && loc_ready;
      bundle_flit  = in_flit;
      bundle_valid = in_valid;
      if (inj) begin
         bundle_flit[slot*FLIT_W +: FLIT_W] = mem[rd_ptr];
         bundle_valid[slot]                 = 1'b1;
      end
      case ({push, inj})
         2'b10:   count_next = q_count + CNT_W'(1);
         2'b01:   count_next = q_count - CNT_W'(1);
         default: count_next = q_count;
      endcase
   end

   // FIFO storage; contents need no reset since pointers and count define validity
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= loc_flit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         q_count     <= '0;
         loc_ready   <= 1'b1;
         out_flit    <= '0;
         out_valid   <= '0;
         inj_fire    <= 1'b0;
         inj_slot    <= '0;
         starve_cnt  <= '0;
         starve_flag <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (inj)  rd_ptr <= rd_ptr + PTR_W'(1);
         q_count     <= count_next;
         loc_ready   <= (count_next < CNT_W'(QDEPTH));
         out_flit    <= bundle_flit;
         out_valid   <= bundle_valid;
         inj_fire    <= inj;
         inj_slot    <= inj ? slot : '0;
         // Saturating starvation counter, cleared by any unblocked cycle
         if (!blocked)                              starve_cnt <= '0;
         else if (starve_cnt != ST_W'(STARVE_MAX))  starve_cnt <= starve_cnt + ST_W'(1);
         starve_flag <= (starve_cnt == ST_W'(STARVE_MAX));
      end
   end

endmodule

// File: tb/tb_inject_queue_stage.sv
// Directed self-checking bench for inject_queue_stage with hand-computed expectations.
module tb_inject_queue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [39:0] in_flit;
   logic [3:0]  in_valid;
   logic [9:0]  loc_flit;
   logic        loc_valid;
   logic        loc_ready;
   logic [39:0] out_flit;
   logic [3:0]  out_valid;
   logic        inj_fire;
   logic [1:0]  inj_slot;
   logic        starve_flag;
   logic [2:0]  q_count;

   int errors = 0;
   int checks = 0;

   inject_queue_stage dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .loc_flit(loc_flit), .loc_valid(loc_valid), .loc_ready(loc_ready),
      .out_flit(out_flit), .out_valid(out_valid), .inj_fire(inj_fire),
      .inj_slot(inj_slot), .starve_flag(starve_flag), .q_count(q_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; loc_valid = 1'b1; loc_flit = 10'h3FF;
      in_valid = 4'b1111; in_flit = {10'h111, 10'h222, 10'h333, 10'h044};
      step(); step();
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got=%b want=0000", out_valid); end
      checks++; if (out_flit !== 40'h0) begin errors++; $display("FAIL rst_out_flit got=%h want=0", out_flit); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_q_count got=%0d want=0", q_count); end
      checks++; if (inj_fire !== 1'b0 || inj_slot !== 2'd0) begin errors++; $display("FAIL rst_inj got=%b/%0d want=0/0", inj_fire, inj_slot); end
      checks++; if (starve_flag !== 1'b0) begin errors++; $display("FAIL rst_starve got=%b want=0", starve_flag); end
      rst = 1'b0; loc_valid = 1'b0;
      step();
      checks++; if (loc_ready !== 1'b1) begin errors++; $display("FAIL rst_loc_ready got=%b want=1", loc_ready); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_release_count got=%0d want=0", q_count); end
   endtask

   task automatic test_free_slot();
      in_valid = 4'b1111; loc_valid = 1'b1; loc_flit = 10'h03F;
      step();
      loc_valid = 1'b0;
      checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL free_push_count got=%0d want=1", q_count); end
      in_valid = 4'b1011; in_flit = {10'h101, 10'h3AA, 10'h102, 10'h103};
      step();
      checks++; if (out_flit[20 +: 10] !== 10'h03F) begin errors++; $display("FAIL free_slot2 got=%h want=03f", out_flit[20 +: 10]); end
      checks++; if (out_flit[0 +: 20] !== 20'h40903 || out_flit[30 +: 10] !== 10'h101) begin errors++; $display("FAIL free_other got=%h want=101xxx40903", out_flit); end
      checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL free_valid got=%b want=1111", out_valid); end
      checks++; if (inj_fire !== 1'b1 || inj_slot !== 2'd2) begin errors++; $display("FAIL free_inj got=%b/%0d want=1/2", inj_fire, inj_slot); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL free_count got=%0d want=0", q_count); end
   endtask

   task automatic test_all_busy();
      in_valid = 4'b1111; loc_valid = 1'b1; loc_flit = 10'h0AA;
      step();
      loc_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++; if (q_count !== 3'd1 || inj_fire !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d] got=%0d/%b want=1/0", i, q_count, inj_fire); end
         checks++; if (starve_flag !== (i >= 16)) begin errors++; $display("FAIL busy_flag[%0d] got=%b want=%b", i, starve_flag, i >= 16); end
      end
      in_valid = 4'b0111;
      step();
      checks++; if (inj_fire !== 1'b1 || inj_slot !== 2'd3 || out_flit[30 +: 10] !== 10'h0AA) begin errors++; $display("FAIL busy_inj got=%b/%0d/%h want=1/3/0aa", inj_fire, inj_slot, out_flit[30 +: 10]); end
      checks++; if (starve_flag !== 1'b1) begin errors++; $display("FAIL busy_flag_hold got=%b want=1", starve_flag); end
      in_valid = 4'b1111;
      step();
      checks++; if (starve_flag !== 1'b0) begin errors++; $display("FAIL busy_flag_drop got=%b want=0", starve_flag); end
   endtask

   task automatic test_fill_wrap();
      in_valid = 4'b1111;
      for (int j = 1; j <= 6; j++) begin
         loc_valid = 1'b1; loc_flit = 10'(j);
         step();
         checks++; if (q_count !== 3'(j > 4 ? 4 : j)) begin errors++; $display("FAIL fill_count[%0d] got=%0d want=%0d", j, q_count, j > 4 ? 4 : j); end
         checks++; if (loc_ready !== (j < 4)) begin errors++; $display("FAIL fill_ready[%0d] got=%b want=%b", j, loc_ready, j < 4); end
      end
      // Full with a pop in the same cycle: offered flit must not be taken
      in_valid = 4'b1110; loc_valid = 1'b1; loc_flit = 10'h3FF;
      for (int k = 1; k <= 4; k++) begin
         step();
         loc_valid = 1'b0;
         checks++; if (out_flit[0 +: 10] !== 10'(k) || inj_fire !== 1'b1 || inj_slot !== 2'd0) begin errors++; $display("FAIL drain[%0d] got=%h/%b/%0d want=%h/1/0", k, out_flit[0 +: 10], inj_fire, inj_slot, 10'(k)); end
         checks++; if (q_count !== 3'(4 - k)) begin errors++; $display("FAIL drain_count[%0d] got=%0d want=%0d", k, q_count, 4 - k); end
      end
      checks++; if (loc_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got=%b want=1", loc_ready); end
   endtask

   task automatic test_push_pop();
      in_valid = 4'b1111; loc_valid = 1'b1; loc_flit = 10'h155;
      step();
      in_valid = 4'b0000; loc_flit = 10'h2AA;
      step();
      loc_valid = 1'b0;
      checks++; if (out_flit[0 +: 10] !== 10'h155 || out_valid !== 4'b0001) begin errors++; $display("FAIL pp_out got=%h/%b want=155/0001", out_flit[0 +: 10], out_valid); end
      checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL pp_count got=%0d want=1", q_count); end
      step();
      checks++; if (out_flit[0 +: 10] !== 10'h2AA || q_count !== 3'd0) begin errors++; $display("FAIL pp_second got=%h/%0d want=2aa/0", out_flit[0 +: 10], q_count); end
   endtask

   task automatic test_pass_through();
      in_flit = {10'h005, 10'h3C3, 10'h221, 10'h027}; in_valid = 4'b1011; loc_valid = 1'b0;
      step();
      checks++; if (out_flit !== {10'h005, 10'h3C3, 10'h221, 10'h027}) begin errors++; $display("FAIL pass_flit got=%h want=%h", out_flit, {10'h005, 10'h3C3, 10'h221, 10'h027}); end
      checks++; if (out_valid !== 4'b1011 || inj_fire !== 1'b0) begin errors++; $display("FAIL pass_valid got=%b/%b want=1011/0", out_valid, inj_fire); end
   endtask

   task automatic test_mid_reset();
      in_valid = 4'b1111; loc_valid = 1'b1; loc_flit = 10'h0F0;
      step(); step();
      loc_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (q_count !== 3'd0 || out_valid !== 4'b0000 || out_flit !== 40'h0) begin errors++; $display("FAIL midrst got=%0d/%b/%h want=0/0000/0", q_count, out_valid, out_flit); end
      in_valid = 4'b0000;
      step();
      checks++; if (inj_fire !== 1'b0 || out_valid !== 4'b0000) begin errors++; $display("FAIL midrst_noinj got=%b/%b want=0/0000", inj_fire, out_valid); end
   endtask

   initial begin
      rst = 1'b1; in_flit = '0; in_valid = '0; loc_flit = '0; loc_valid = 1'b0;
      test_reset();
      test_free_slot();
      test_all_busy();
      test_fill_wrap();
      test_push_pop();
      test_pass_through();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
